// File: rtl/pid_pkg.sv
// Shared definitions for the PID loop sequencer: FSM states, default sizes
// and status bit positions used by the register-block readback.
package pid_pkg;

    localparam int DW_DEF      = 32;
    localparam int TW_DEF      = 32;
    localparam int TIMEOUT_DEF = 64;

    localparam int STAT_OVERRUN = 0;
    localparam int STAT_TIMEOUT = 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TICK = 2'd1,
        ST_LAUNCH    = 2'd2,
        ST_WAIT_CMP  = 2'd3
    } pid_state_e;

endpackage

// File: rtl/pid_ref_ramp.sv
// Next-reference function: steps ref_cur toward target_ref by at most
// ramp_step, landing exactly on the target without overshoot or wrap.
module pid_ref_ramp
    import pid_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0] ref_cur,
    input  logic [DW-1:0] target_ref,
    input  logic [DW-1:0] ramp_step,
    output logic [DW-1:0] ref_nxt
);

    // Distance is computed in the non-negative direction only, so the
    // +/- step below can never cross the target or wrap.
    always_comb begin
        ref_nxt = target_ref;
        if (ramp_step != '0) begin
            if (target_ref >= ref_cur) begin
                if ((target_ref - ref_cur) > ramp_step) begin
                    ref_nxt = ref_cur + ramp_step;
                end
            end else begin
                if ((ref_cur - target_ref) > ramp_step) begin
                    ref_nxt = ref_cur - ramp_step;
                end
            end
        end
    end

endmodule

// File: rtl/pid_loop_sequencer.sv
// Sample-rate sequencer around one PID core: ticks, ramps the reference,
// launches the core, publishes its result and flags overruns and hangs.
module pid_loop_sequencer
    import pid_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int TW      = TW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          loop_en,
    input  logic [TW-1:0] period,
    input  logic [DW-1:0] target_ref,
    input  logic [DW-1:0] ramp_step,
    input  logic [DW-1:0] fdb_in,
    input  logic          clr_status,
    output logic [DW-1:0] core_ref,
    output logic [DW-1:0] core_fdb,
    output logic          core_en,
    input  logic          core_cmp,
    input  logic [DW-1:0] core_out,
    output logic [DW-1:0] ctrl_out,
    output logic          ctrl_valid,
    output logic          busy,
    output logic [DW-1:0] ref_cur,
    output logic          overrun_sticky,
    output logic          timeout_sticky,
    output pid_state_e    state_dbg
);

    localparam int TOW = $clog2(TIMEOUT + 1);

    pid_state_e    state;
    pid_state_e    state_nxt;
    logic [TW-1:0] tick_cnt;
    logic [TW-1:0] period_eff;
    logic          tick;
    logic [TOW-1:0] to_cnt;
    logic          to_expire;
    logic          overrun_set;
    logic          timeout_set;
    logic [DW-1:0] ref_nxt;

    // Periods below 2 would leave no cycle for the count to advance.
    assign period_eff = (period < TW'(2)) ? TW'(2) : period;
    assign tick       = loop_en && (tick_cnt == (period_eff - TW'(1)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (!loop_en || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    pid_ref_ramp #(.DW(DW)) u_ramp (
        .ref_cur    (ref_cur),
        .target_ref (target_ref),
        .ramp_step  (ramp_step),
        .ref_nxt    (ref_nxt)
    );

    assign to_expire = (to_cnt == TOW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Valid/ready contract with the core: core_en is a single-cycle request,
    // core_cmp is accepted only in WAIT_CMP and completion beats the timeout.
    always_comb begin
        state_nxt = state;
        core_en   = 1'b0;
        busy      = 1'b0;
        if (!loop_en) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:      state_nxt = ST_WAIT_TICK;
                ST_WAIT_TICK: if (tick) state_nxt = ST_LAUNCH;
                ST_LAUNCH: begin
                    core_en   = 1'b1;
                    state_nxt = ST_WAIT_CMP;
                end
                ST_WAIT_CMP:  if (core_cmp || to_expire) state_nxt = ST_WAIT_TICK;
                default:      state_nxt = ST_IDLE;
            endcase
        end
        if (state == ST_LAUNCH || state == ST_WAIT_CMP) begin
            busy = 1'b1;
        end
    end

    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
        end else if (state == ST_LAUNCH) begin
            to_cnt <= '0;
        end else if (state == ST_WAIT_CMP && !to_expire) begin
            to_cnt <= to_cnt + TOW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ref_cur    <= '0;
            core_ref   <= '0;
            core_fdb   <= '0;
            ctrl_out   <= '0;
            ctrl_valid <= 1'b0;
        end else begin
            ctrl_valid <= 1'b0;
            if (!loop_en) begin
                ctrl_out <= '0;
            end else begin
                case (state)
                    ST_IDLE: ref_cur <= fdb_in;
                    ST_WAIT_TICK: begin
                        if (tick) begin
                            core_fdb <= fdb_in;
                            ref_cur  <= ref_nxt;
                            core_ref <= ref_nxt;
                        end
                    end
                    ST_WAIT_CMP: begin
                        if (core_cmp) begin
                            ctrl_out   <= core_out;
                            ctrl_valid <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign overrun_set = tick && (state != ST_WAIT_TICK);
    assign timeout_set = loop_en && (state == ST_WAIT_CMP) && !core_cmp && to_expire;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_sticky <= 1'b0;
            timeout_sticky <= 1'b0;
        end else begin
            if (overrun_set) begin
                overrun_sticky <= 1'b1;
            end else if (clr_status) begin
                overrun_sticky <= 1'b0;
            end
            if (timeout_set) begin
                timeout_sticky <= 1'b1;
            end else if (clr_status) begin
                timeout_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pid_loop_sequencer.sv
// Bench for pid_loop_sequencer: directed phases push expected launches and
// results (with their cycle numbers) into queues; a monitor pops and compares.
module tb_pid_loop_sequencer;
    import pid_pkg::*;

    localparam int DW = 32;
    localparam int TW = 32;
    localparam int TIMEOUT = 64;
    localparam int LW = 32 + 2 * DW;
    localparam int CW = 32 + DW;

    logic          clk;
    logic          reset_n;
    logic          loop_en;
    logic [TW-1:0] period;
    logic [DW-1:0] target_ref;
    logic [DW-1:0] ramp_step;
    logic [DW-1:0] fdb_in;
    logic          clr_status;
    logic [DW-1:0] core_ref;
    logic [DW-1:0] core_fdb;
    logic          core_en;
    logic          core_cmp;
    logic [DW-1:0] core_out;
    logic [DW-1:0] ctrl_out;
    logic          ctrl_valid;
    logic          busy;
    logic [DW-1:0] ref_cur;
    logic          overrun_sticky;
    logic          timeout_sticky;
    pid_state_e    state_dbg;

    logic          core_hang;
    int            core_lat;
    logic [DW-1:0] core_val;
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            a;
    logic [LW-1:0] launch_q[$];
    logic [CW-1:0] ctrl_q[$];
    logic [DW-1:0] ramp_exp [7];

    pid_loop_sequencer #(.DW(DW), .TW(TW), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .loop_en        (loop_en),
        .period         (period),
        .target_ref     (target_ref),
        .ramp_step      (ramp_step),
        .fdb_in         (fdb_in),
        .clr_status     (clr_status),
        .core_ref       (core_ref),
        .core_fdb       (core_fdb),
        .core_en        (core_en),
        .core_cmp       (core_cmp),
        .core_out       (core_out),
        .ctrl_out       (ctrl_out),
        .ctrl_valid     (ctrl_valid),
        .busy           (busy),
        .ref_cur        (ref_cur),
        .overrun_sticky (overrun_sticky),
        .timeout_sticky (timeout_sticky),
        .state_dbg      (state_dbg)
    );

    // Clock and cycle index: inside cycle k (after its rising edge) cyc == k.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_launch(input int c, input logic [DW-1:0] r, input logic [DW-1:0] f);
        launch_q.push_back({32'(c), r, f});
    endtask

    task automatic exp_ctrl(input int c, input logic [DW-1:0] v);
        ctrl_q.push_back({32'(c), v});
    endtask

    task automatic phase_end(input string name);
        chk({name, "_launches_left"}, 32'(launch_q.size()), 32'd0);
        chk({name, "_results_left"}, 32'(ctrl_q.size()), 32'd0);
        launch_q.delete();
        ctrl_q.delete();
    endtask

    // Core model: answers core_en with core_cmp core_lat cycles later.
    initial begin
        core_cmp = 1'b0;
        core_out = 32'hDEAD_0000;
        forever begin
            @(negedge clk);
            if (reset_n && core_en && !core_hang) begin
                repeat (core_lat) @(posedge clk);
                #1;
                core_cmp = 1'b1;
                core_out = core_val;
                @(posedge clk);
                #1;
                core_cmp = 1'b0;
                core_out = 32'hDEAD_0000;
            end
        end
    end

    // Monitor: every launch and every published result must match the queue head.
    always @(negedge clk) begin
        logic [LW-1:0] el;
        logic [CW-1:0] ec;
        if (reset_n) begin
            if (core_en) begin
                if (launch_q.size() == 0) begin
                    chk("extra_core_en_cycle", 32'(cyc), 32'hFFFF_FFFF);
                end else begin
                    el = launch_q.pop_front();
                    chk("launch_cycle", 32'(cyc), el[LW-1 -: 32]);
                    chk("core_ref", core_ref, el[2*DW-1:DW]);
                    chk("core_fdb", core_fdb, el[DW-1:0]);
                end
            end
            if (ctrl_valid) begin
                if (ctrl_q.size() == 0) begin
                    chk("extra_ctrl_valid_cycle", 32'(cyc), 32'hFFFF_FFFF);
                end else begin
                    ec = ctrl_q.pop_front();
                    chk("ctrl_valid_cycle", 32'(cyc), ec[CW-1 -: 32]);
                    chk("ctrl_out", ctrl_out, ec[DW-1:0]);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0; loop_en = 1'b0; period = 10; target_ref = '0; ramp_step = '0;
        fdb_in = '0; clr_status = 1'b0; core_hang = 1'b0; core_lat = 3; core_val = '0;
        ramp_exp = '{32'h10, 32'h20, 32'h30, 32'h30, 32'h20, 32'h10, 32'h05};
        wait_cyc(3);
        reset_n = 1'b1;
        wait_cyc(1);
        chk("reset_state", 32'(state_dbg), 32'(ST_IDLE));
        chk("reset_ctrl_out", ctrl_out, '0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_sticky", {30'd0, timeout_sticky, overrun_sticky}, 32'd0);

        // Basic loop: fixed reference, result every 10 cycles
        period = 10; target_ref = 32'h100; fdb_in = 32'h40; core_val = 32'h1234;
        loop_en = 1'b1; a = cyc;
        for (int j = 1; j <= 3; j++) begin
            exp_launch(a + 10 * j, 32'h100, 32'h40);
            exp_ctrl(a + 10 * j + 4, 32'h1234);
        end
        wait_cyc(35);
        loop_en = 1'b0;
        wait_cyc(1);
        chk("disable_state", 32'(state_dbg), 32'(ST_IDLE));
        chk("disable_ctrl_out", ctrl_out, '0);
        phase_end("basic");
        wait_cyc(2);

        // Ramp up then down, bumpless start from fdb_in = 0
        fdb_in = '0; target_ref = 32'h30; ramp_step = 32'h10; core_val = 32'h0ABC;
        loop_en = 1'b1; a = cyc;
        for (int j = 0; j < 7; j++) begin
            exp_launch(a + 10 * (j + 1), ramp_exp[j], '0);
            exp_ctrl(a + 10 * (j + 1) + 4, 32'h0ABC);
        end
        wait_cyc(1);
        chk("bumpless_ref_cur", ref_cur, '0);
        wait_cyc(41);
        target_ref = 32'h05;
        wait_cyc(33);
        chk("ramp_final_ref_cur", ref_cur, 32'h05);
        loop_en = 1'b0;
        wait_cyc(2);
        phase_end("ramp");

        // Timeout: first sample completes, later ones hang
        period = 200; ramp_step = '0; target_ref = 32'h77; fdb_in = 32'h11; core_val = 32'h5555;
        loop_en = 1'b1; a = cyc;
        for (int j = 1; j <= 3; j++) exp_launch(a + 200 * j, 32'h77, 32'h11);
        exp_ctrl(a + 204, 32'h5555);
        wait_cyc(210);
        core_hang = 1'b1;
        wait_cyc(254);
        chk("timeout_before_expiry", 32'(timeout_sticky), 32'd0);
        wait_cyc(1);
        chk("timeout_at_launch_plus_65", 32'(timeout_sticky), 32'd1);
        chk("timeout_ctrl_out_held", ctrl_out, 32'h5555);
        chk("timeout_back_to_wait_tick", 32'(state_dbg), 32'(ST_WAIT_TICK));
        wait_cyc(145);
        clr_status = 1'b1;
        wait_cyc(1);
        clr_status = 1'b0;
        chk("timeout_cleared", 32'(timeout_sticky), 32'd0);
        wait_cyc(53);
        clr_status = 1'b1;
        wait_cyc(1);
        clr_status = 1'b0;
        chk("clr_vs_expiry_set_wins", 32'(timeout_sticky), 32'd1);
        wait_cyc(1);
        clr_status = 1'b1;
        wait_cyc(1);
        clr_status = 1'b0;
        chk("timeout_cleared_again", 32'(timeout_sticky), 32'd0);
        loop_en = 1'b0; core_hang = 1'b0;
        wait_cyc(2);
        phase_end("timeout");

        // Overrun: period 4, core needs 10 cycles
        period = 4; core_lat = 10; core_val = 32'h0F0F; target_ref = 32'h22; fdb_in = 32'h33;
        loop_en = 1'b1; a = cyc;
        exp_launch(a + 4, 32'h22, 32'h33);
        exp_launch(a + 16, 32'h22, 32'h33);
        exp_ctrl(a + 15, 32'h0F0F);
        wait_cyc(7);
        chk("overrun_before_drop", 32'(overrun_sticky), 32'd0);
        wait_cyc(1);
        chk("overrun_after_drop", 32'(overrun_sticky), 32'd1);
        wait_cyc(12);
        loop_en = 1'b0;
        wait_cyc(1);
        chk("overrun_disable_busy", 32'(busy), 32'd0);
        wait_cyc(9);
        chk("late_cmp_ctrl_out", ctrl_out, '0);
        phase_end("overrun");

        // Disable during WAIT_CMP, late completion two cycles later
        period = 10; core_lat = 3; core_val = 32'h4242; target_ref = 32'h50; fdb_in = 32'h60;
        loop_en = 1'b1; a = cyc;
        exp_launch(a + 10, 32'h50, 32'h60);
        exp_launch(a + 20, 32'h50, 32'h60);
        exp_ctrl(a + 14, 32'h4242);
        wait_cyc(15);
        core_lat = 4;
        chk("mid_ctrl_out_before", ctrl_out, 32'h4242);
        wait_cyc(7);
        chk("mid_state_wait_cmp", 32'(state_dbg), 32'(ST_WAIT_CMP));
        loop_en = 1'b0;
        wait_cyc(1);
        chk("mid_state_idle", 32'(state_dbg), 32'(ST_IDLE));
        chk("mid_ctrl_out_safe", ctrl_out, '0);
        wait_cyc(3);
        chk("mid_ctrl_out_after_late_cmp", ctrl_out, '0);
        chk("overrun_retained", 32'(overrun_sticky), 32'd1);
        fdb_in = 32'h99; loop_en = 1'b1;
        wait_cyc(1);
        chk("reenable_ref_cur", ref_cur, 32'h99);
        loop_en = 1'b0; clr_status = 1'b1;
        wait_cyc(1);
        clr_status = 1'b0;
        chk("overrun_cleared", 32'(overrun_sticky), 32'd0);
        wait_cyc(1);
        phase_end("disable");

        // Period 0 and 1 behave as 2
        core_lat = 1; core_val = 32'h0C0C; target_ref = 32'h10; fdb_in = 32'h20;
        for (int p = 0; p < 2; p++) begin
            period = TW'(p);
            loop_en = 1'b1; a = cyc;
            for (int j = 0; j < 3; j++) begin
                exp_launch(a + 2 + 4 * j, 32'h10, 32'h20);
                exp_ctrl(a + 4 + 4 * j, 32'h0C0C);
            end
            wait_cyc(13);
            loop_en = 1'b0;
            wait_cyc(2);
            phase_end("short_period");
        end

        // Asynchronous reset in the middle of WAIT_CMP
        period = 10; core_lat = 3; core_val = 32'h7777; target_ref = 32'h44; fdb_in = 32'h55;
        loop_en = 1'b1; a = cyc;
        exp_launch(a + 10, 32'h44, 32'h55);
        exp_launch(a + 20, 32'h44, 32'h55);
        exp_ctrl(a + 14, 32'h7777);
        wait_cyc(15);
        core_lat = 30;
        wait_cyc(8);
        chk("prereset_busy", 32'(busy), 32'd1);
        chk("prereset_ctrl_out", ctrl_out, 32'h7777);
        chk("prereset_overrun", 32'(overrun_sticky), 32'd1);
        @(negedge clk);
        reset_n = 1'b0; loop_en = 1'b0;
        #1;
        chk("areset_ctrl_out", ctrl_out, '0);
        chk("areset_flags", {27'd0, ctrl_valid, core_en, busy, timeout_sticky, overrun_sticky}, 32'd0);
        chk("areset_ref", ref_cur | core_ref | core_fdb, '0);
        chk("areset_state", 32'(state_dbg), 32'(ST_IDLE));
        wait_cyc(2);
        reset_n = 1'b1;
        wait_cyc(32);
        chk("postreset_ctrl_out", ctrl_out, '0);
        phase_end("reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
